// File: rtl/blink_code_pkg.sv
// Shared state encoding and default timing for the blink-code transmitter.
// The defaults give 1 ms ticks at 125 MHz.
package blink_code_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int unsigned DEF_TICK_DIV  = 125000;
    localparam int unsigned DEF_ON_TICKS  = 200;
    localparam int unsigned DEF_OFF_TICKS = 200;
    localparam int unsigned DEF_GAP_TICKS = 1000;
    localparam int unsigned DEF_VAL_W     = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/blink_code_tx_if.sv
// Code handshake between a sender of blink codes and the transmitter.
interface blink_code_tx_if #(
    parameter int unsigned VAL_W = 3
);
    logic [VAL_W-1:0] code;
    logic             code_valid;
    logic             code_ready;

    modport master (output code, output code_valid, input  code_ready);
    modport slave  (input  code, input  code_valid, output code_ready);
endinterface

// File: rtl/blink_code_tx_tick_prescaler.sv
// Free-running divider that strobes tick for one cycle every DIV enabled cycles.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int unsigned   PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/blink_code_tx.sv
// Emits an accepted code N as N LED pulses followed by a dark gap, one code per frame.
module blink_code_tx
    import blink_code_pkg::*;
#(
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
    parameter int unsigned VAL_W     = DEF_VAL_W
) (
    input  logic            CLK_IN,
    input  logic            CPU_RESETN,
    blink_code_tx_if.slave  bus,
    output logic            led_out,
    output logic            busy,
    output logic            done
);
    localparam int unsigned TW = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS)) + 1;

    state_t           state, state_next;
    logic             tick, accept, last_tick, idle;
    logic [TW-1:0]    tick_cnt, tick_last;
    logic [VAL_W-1:0] blink_cnt, blink_dec;
    logic             led_d, busy_d, ready_d, done_d;

    assign idle      = (state == IDLE);
    assign accept    = bus.code_valid && bus.code_ready;
    assign blink_dec = blink_cnt - 1'b1;

    // The prescaler is held clear while idle, so every frame starts on a fresh tick phase.
    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk    (CLK_IN),
        .rst_n  (CPU_RESETN),
        .clear  (idle),
        .enable (!idle),
        .tick   (tick)
    );

    always_comb begin
        unique case (state)
            ON:      tick_last = TW'(ON_TICKS - 1);
            OFF:     tick_last = TW'(OFF_TICKS - 1);
            default: tick_last = TW'(GAP_TICKS - 1);
        endcase
    end

    assign last_tick = tick && (tick_cnt == tick_last);

    always_ff @(posedge CLK_IN) begin
        if (!CPU_RESETN) begin
            state          <= IDLE;
            led_out        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.code_ready <= 1'b1;
        end else begin
            state          <= state_next;
            led_out        <= led_d;
            busy           <= busy_d;
            done           <= done_d;
            bus.code_ready <= ready_d;
        end
    end

    always_comb begin
        // NOTE: defaulting every combinational output first keeps paths that
        // don't assign it from inferring a latch.
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = (bus.code != '0) ? ON : GAP;
            ON:   if (last_tick) state_next = OFF;
            OFF:  if (last_tick) state_next = (blink_dec != '0) ? ON : GAP;
            GAP:  if (last_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        led_d   = (state_next == ON);
        busy_d  = (state_next != IDLE);
        ready_d = (state_next == IDLE);
        done_d  = (state == GAP) && (state_next == IDLE);
    end

    // Tick counter restarts on every state entry because entries only happen on last_tick.
    always_ff @(posedge CLK_IN) begin
        if (!CPU_RESETN) begin
            tick_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            if (idle || last_tick) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (accept) begin
                blink_cnt <= bus.code;
            end else if ((state == OFF) && last_tick) begin
                blink_cnt <= blink_dec;
            end
        end
    end
endmodule

// File: tb/tb_blink_code_tx.sv
// Directed bench for blink_code_tx with TICK_DIV=4, ON=2, OFF=3, GAP=5 ticks.
module tb_blink_code_tx;
    localparam int VAL_W   = 3;
    localparam int ON_CYC  = 8;   // 2 ticks * 4 cycles
    localparam int PER_CYC = 20;  // (2 + 3) ticks * 4 cycles
    localparam int GAP_CYC = 20;  // 5 ticks * 4 cycles

    logic clk = 1'b0;
    logic rst_n;
    logic led_out, busy, done;
    int   n_vec = 0;
    int   n_err = 0;

    blink_code_tx_if #(.VAL_W(VAL_W)) bus ();

    blink_code_tx #(
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .OFF_TICKS (3),
        .GAP_TICKS (5),
        .VAL_W     (VAL_W)
    ) dut (
        .CLK_IN     (clk),
        .CPU_RESETN (rst_n),
        .bus        (bus),
        .led_out    (led_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_led(input int k, input int n);
        int p;
        p = k - 1;
        if (p < n * PER_CYC) return ((p % PER_CYC) < ON_CYC);
        return 1'b0;
    endfunction

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " led"},   led_out,        0);
        check({tag, " busy"},  busy,           0);
        check({tag, " done"},  done,           exp_done);
        check({tag, " ready"}, bus.code_ready, 1);
    endtask

    // Entered in cycle 1 after the accept edge. A nonzero poke drives code=5 with
    // code_valid for two edges mid-frame; a nonzero stop_at leaves the frame early.
    task automatic watch(input string tag, input int n, input int poke, input int stop_at);
        int   total, last, pulses;
        logic prev;
        total  = n * PER_CYC + GAP_CYC;
        last   = (stop_at > 0) ? stop_at : total;
        pulses = 0;
        prev   = 1'b0;
        for (int k = 1; k <= last; k++) begin
            check($sformatf("%s led k=%0d", tag, k),   led_out,        exp_led(k, n));
            check($sformatf("%s busy k=%0d", tag, k),  busy,           1);
            check($sformatf("%s ready k=%0d", tag, k), bus.code_ready, 0);
            check($sformatf("%s done k=%0d", tag, k),  done,           0);
            if (led_out && !prev) pulses++;
            prev = led_out;
            if (poke > 0) begin
                if (k == poke) begin
                    bus.code       = 3'd5;
                    bus.code_valid = 1'b1;
                end else if (k == poke + 2) begin
                    bus.code_valid = 1'b0;
                end
            end
            step();
        end
        if (stop_at == 0) begin
            check_idle({tag, " end"}, 1'b1);
            check({tag, " pulses"}, pulses, n);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.code       = '0;
        bus.code_valid = 1'b0;

        // 1: reset held for three edges, then released
        repeat (3) step();
        check_idle("rst", 1'b0);
        rst_n = 1'b1;
        step();
        check_idle("post_rst", 1'b0);

        // 2: code 3, code changes after accept without effect
        bus.code       = 3'd3;
        bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        bus.code       = 3'd6;
        watch("c3", 3, 0, 0);
        step();
        check_idle("c3 after", 1'b0);

        // 3: code 0 gives only the gap
        bus.code       = 3'd0;
        bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        watch("c0", 0, 0, 0);
        step();
        check_idle("c0 after", 1'b0);

        // 4: valid held high, second frame accepted on the done cycle
        bus.code       = 3'd1;
        bus.code_valid = 1'b1;
        step();
        bus.code = 3'd2;
        watch("b2b1", 1, 0, 0);
        step();
        watch("b2b2", 2, 0, 0);
        bus.code_valid = 1'b0;
        step();
        check_idle("b2b after", 1'b0);

        // 5: code_valid during a frame is ignored
        bus.code       = 3'd2;
        bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        watch("ign", 2, 10, 0);
        step();
        check_idle("ign after", 1'b0);

        // 6: reset during the 4th ON of code 7, then a normal frame
        bus.code       = 3'd7;
        bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        watch("abort", 7, 0, 62);
        check("abort led_on", led_out, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("abort rst", 1'b0);
        step();
        check_idle("abort idle", 1'b0);
        bus.code       = 3'd1;
        bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        watch("c1", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
